// File: rtl/jtag_ahb_pkg.sv
// Shared encodings for the JTAG-to-AHB access controller.
package jtag_ahb_pkg;

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransNonseq = 2'b10;

    localparam logic HrespOkay  = 1'b0;
    localparam logic HrespError = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t StIdle = 3'd0;
    localparam state_t StAddr = 3'd1;
    localparam state_t StData = 3'd2;
    localparam state_t StErr2 = 3'd3;
    localparam state_t StResp = 3'd4;

endpackage

// File: rtl/jtag_ahb_rr_arb.sv
// Two-way combinational arbiter: alternates on contention when ROUND_ROBIN is set,
// otherwise port 0 has fixed priority.
module jtag_ahb_rr_arb #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic any_req,
    output logic grant
);

    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            grant = ROUND_ROBIN ? ~last_grant : 1'b0;
        end else begin
            grant = ~req0;
        end
    end

endmodule

// File: rtl/jtag_ahb_access_ctrl.sv
// Arbitrates two requesters onto one AHB-Lite master port, issuing single-beat NONSEQ
// transfers with wait-state, two-cycle error and watchdog-abort handling.
module jtag_ahb_access_ctrl
    import jtag_ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ROUND_ROBIN    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  TCK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic                  WR0,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    input  logic [DATA_WIDTH-1:0] WDATA0,
    output logic                  ACK0,
    output logic                  ERR0,
    output logic [DATA_WIDTH-1:0] RDATA0,
    input  logic                  REQ1,
    input  logic                  WR1,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    input  logic [DATA_WIDTH-1:0] WDATA1,
    output logic                  ACK1,
    output logic                  ERR1,
    output logic [DATA_WIDTH-1:0] RDATA1,
    input  logic                  HREADY,
    input  logic                  HRESP,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HWRITE,
    output logic [1:0]            HTRANS,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [DATA_WIDTH-1:0] HWDATA,
    output logic                  TIMEOUT_FLAG
);

    state_t      state_q, state_d;
    logic        owner_q;
    logic        last_grant_q;
    logic [15:0] wdog_q;
    logic [16:0] wdog_next;

    logic any_req, grant;
    logic grab, accept, finish, fin_err, fin_read, wd_inc, tmo, wd_hit;

    jtag_ahb_rr_arb #(
        .ROUND_ROBIN(ROUND_ROBIN != 0)
    ) u_arb (
        .req0      (REQ0),
        .req1      (REQ1),
        .last_grant(last_grant_q),
        .any_req   (any_req),
        .grant     (grant)
    );

    // The wait cycle that would bring the count to TIMEOUT_CYCLES aborts instead.
    assign wdog_next = {1'b0, wdog_q} + 17'd1;
    assign wd_hit    = (wdog_next == 17'(TIMEOUT_CYCLES));

    always_comb begin
        state_d  = state_q;
        grab     = 1'b0;
        accept   = 1'b0;
        finish   = 1'b0;
        fin_err  = 1'b0;
        fin_read = 1'b0;
        wd_inc   = 1'b0;
        tmo      = 1'b0;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    grab    = 1'b1;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (HREADY) begin
                    accept  = 1'b1;
                    state_d = StData;
                end
            end
            StData: begin
                if (HREADY) begin
                    finish   = 1'b1;
                    fin_err  = (HRESP == HrespError);
                    fin_read = (HRESP == HrespOkay) && !HWRITE;
                end else if (HRESP == HrespError) begin
                    state_d = StErr2;
                end else if (wd_hit) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                    tmo     = 1'b1;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            StErr2: begin
                if (HREADY) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end else if (wd_hit) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                    tmo     = 1'b1;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (finish) state_d = StResp;
    end

    always_ff @(posedge TCK) begin
        if (RST) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wdog_q       <= '0;
            HTRANS       <= HtransIdle;
            HWRITE       <= 1'b0;
            HADDR        <= '0;
            HWDATA       <= '0;
            ACK0         <= 1'b0;
            ERR0         <= 1'b0;
            RDATA0       <= '0;
            ACK1         <= 1'b0;
            ERR1         <= 1'b0;
            RDATA1       <= '0;
            TIMEOUT_FLAG <= 1'b0;
        end else begin
            state_q <= state_d;
            ACK0    <= 1'b0;
            ACK1    <= 1'b0;
            if (grab) begin
                owner_q      <= grant;
                last_grant_q <= grant;
                HADDR        <= grant ? ADDR1 : ADDR0;
                HWRITE       <= grant ? WR1 : WR0;
                HTRANS       <= HtransNonseq;
            end
            if (accept) begin
                HTRANS <= HtransIdle;
                wdog_q <= '0;
                if (HWRITE) HWDATA <= owner_q ? WDATA1 : WDATA0;
            end
            if (wd_inc) wdog_q <= wdog_q + 16'd1;
            if (tmo) TIMEOUT_FLAG <= 1'b1;
            if (finish) begin
                if (owner_q) begin
                    ACK1 <= 1'b1;
                    ERR1 <= fin_err;
                    if (fin_read) RDATA1 <= HRDATA;
                end else begin
                    ACK0 <= 1'b1;
                    ERR0 <= fin_err;
                    if (fin_read) RDATA0 <= HRDATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_ahb_access_ctrl.sv
// Bench for jtag_ahb_access_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level reference model.
module tb_jtag_ahb_access_ctrl;

    localparam int TMO = 8;

    logic        TCK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ0 = 1'b0, WR0 = 1'b0, REQ1 = 1'b0, WR1 = 1'b0;
    logic [31:0] ADDR0 = '0, WDATA0 = '0, ADDR1 = '0, WDATA1 = '0;
    logic        HREADY = 1'b1, HRESP = 1'b0;
    logic [31:0] HRDATA = '0;

    logic        ACK0, ERR0, ACK1, ERR1, HWRITE, TIMEOUT_FLAG;
    logic [31:0] RDATA0, RDATA1, HADDR, HWDATA;
    logic [1:0]  HTRANS;

    logic        f_ACK0, f_ERR0, f_ACK1, f_ERR1, f_HWRITE, f_TIMEOUT_FLAG;
    logic [31:0] f_RDATA0, f_RDATA1, f_HADDR, f_HWDATA;
    logic [1:0]  f_HTRANS;

    always #5 TCK = ~TCK;

    jtag_ahb_access_ctrl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .TCK(TCK), .RST(RST),
        .REQ0(REQ0), .WR0(WR0), .ADDR0(ADDR0), .WDATA0(WDATA0),
        .ACK0(ACK0), .ERR0(ERR0), .RDATA0(RDATA0),
        .REQ1(REQ1), .WR1(WR1), .ADDR1(ADDR1), .WDATA1(WDATA1),
        .ACK1(ACK1), .ERR1(ERR1), .RDATA1(RDATA1),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
        .HWRITE(HWRITE), .HTRANS(HTRANS), .HADDR(HADDR), .HWDATA(HWDATA),
        .TIMEOUT_FLAG(TIMEOUT_FLAG)
    );

    // Fixed-priority instance sharing the same stimulus.
    jtag_ahb_access_ctrl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(TMO)
    ) dut_fp (
        .TCK(TCK), .RST(RST),
        .REQ0(REQ0), .WR0(WR0), .ADDR0(ADDR0), .WDATA0(WDATA0),
        .ACK0(f_ACK0), .ERR0(f_ERR0), .RDATA0(f_RDATA0),
        .REQ1(REQ1), .WR1(WR1), .ADDR1(ADDR1), .WDATA1(WDATA1),
        .ACK1(f_ACK1), .ERR1(f_ERR1), .RDATA1(f_RDATA1),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
        .HWRITE(f_HWRITE), .HTRANS(f_HTRANS), .HADDR(f_HADDR), .HWDATA(f_HWDATA),
        .TIMEOUT_FLAG(f_TIMEOUT_FLAG)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge TCK);
    endtask

    // Reference model: transfer phases of the round-robin instance.
    localparam int P_FREE = 0, P_ADDR = 1, P_DATA = 2, P_ERRW = 3, P_ACK = 4;
    int          m_phase = P_FREE, m_own = 0, m_last = 1, m_wait = 0;
    logic [1:0]  e_htrans = 2'b00;
    logic        e_hwrite = 1'b0, e_tflag = 1'b0;
    logic [31:0] e_haddr = '0, e_hwdata = '0;
    logic        e_ack[2] = '{1'b0, 1'b0};
    logic        e_err[2] = '{1'b0, 1'b0};
    logic [31:0] e_rdata[2] = '{32'h0, 32'h0};

    task automatic model_complete(input logic err, input logic capture);
        e_ack[m_own] = 1'b1;
        e_err[m_own] = err;
        if (capture) e_rdata[m_own] = HRDATA;
        m_phase = P_ACK;
    endtask

    task automatic model_wait_cycle;
        m_wait++;
        if (m_wait == TMO) begin
            e_tflag = 1'b1;
            model_complete(1'b1, 1'b0);
        end
    endtask

    task automatic model_step;
        int w;
        if (RST) begin
            m_phase = P_FREE; m_own = 0; m_last = 1; m_wait = 0;
            e_htrans = 2'b00; e_hwrite = 1'b0; e_haddr = '0; e_hwdata = '0; e_tflag = 1'b0;
            for (int p = 0; p < 2; p++) begin
                e_ack[p] = 1'b0; e_err[p] = 1'b0; e_rdata[p] = '0;
            end
            return;
        end
        e_ack[0] = 1'b0;
        e_ack[1] = 1'b0;
        case (m_phase)
            P_FREE: if (REQ0 || REQ1) begin
                w = (REQ0 && REQ1) ? 1 - m_last : (REQ0 ? 0 : 1);
                m_own = w; m_last = w;
                e_haddr  = (w == 1) ? ADDR1 : ADDR0;
                e_hwrite = (w == 1) ? WR1 : WR0;
                e_htrans = 2'b10;
                m_phase  = P_ADDR;
            end
            P_ADDR: if (HREADY) begin
                e_htrans = 2'b00;
                if (e_hwrite) e_hwdata = (m_own == 1) ? WDATA1 : WDATA0;
                m_wait  = 0;
                m_phase = P_DATA;
            end
            P_DATA: begin
                if (HREADY) model_complete(HRESP, !HRESP && !e_hwrite);
                else if (HRESP) m_phase = P_ERRW;
                else model_wait_cycle();
            end
            P_ERRW: begin
                if (HREADY) model_complete(1'b1, 1'b0);
                else model_wait_cycle();
            end
            default: m_phase = P_FREE;
        endcase
    endtask

    always @(posedge TCK) model_step();

    bit chk_en = 1'b0;
    always @(negedge TCK) begin
        if (chk_en) begin
            check("m_htrans", 32'(HTRANS), 32'(e_htrans));
            check("m_hwrite", 32'(HWRITE), 32'(e_hwrite));
            check("m_haddr", HADDR, e_haddr);
            check("m_hwdata", HWDATA, e_hwdata);
            check("m_ack0", 32'(ACK0), 32'(e_ack[0]));
            check("m_ack1", 32'(ACK1), 32'(e_ack[1]));
            check("m_err0", 32'(ERR0), 32'(e_err[0]));
            check("m_err1", 32'(ERR1), 32'(e_err[1]));
            check("m_rdata0", RDATA0, e_rdata[0]);
            check("m_rdata1", RDATA1, e_rdata[1]);
            check("m_tflag", 32'(TIMEOUT_FLAG), 32'(e_tflag));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_rr, n_fp, ack_cyc, stuck;
        int ord_rr[4];
        int ord_fp[4];
        int exp_rr[4] = '{0, 1, 0, 1};

        RST = 1'b1;
        tick; tick;
        chk_en = 1'b1;
        check("rst_htrans", 32'(HTRANS), 0);
        check("rst_haddr", HADDR, 0);
        check("rst_hwdata", HWDATA, 0);
        check("rst_ack0", 32'(ACK0), 0);
        check("rst_rdata0", RDATA0, 0);
        check("rst_tflag", 32'(TIMEOUT_FLAG), 0);

        // Zero-wait write on port 0
        RST = 1'b0; REQ0 = 1'b1; WR0 = 1'b1; ADDR0 = 32'h1000; WDATA0 = 32'hDEADBEEF;
        tick;
        check("wr_c1_htrans", 32'(HTRANS), 32'h2);
        check("wr_c1_haddr", HADDR, 32'h1000);
        check("wr_c1_hwrite", 32'(HWRITE), 1);
        tick;
        check("wr_c2_hwdata", HWDATA, 32'hDEADBEEF);
        check("wr_c2_htrans", 32'(HTRANS), 0);
        ADDR0 = 32'hFFFF0000; WDATA0 = 32'h0;
        tick;
        check("wr_c3_ack0", 32'(ACK0), 1);
        check("wr_c3_err0", 32'(ERR0), 0);
        REQ0 = 1'b0;
        tick;
        check("wr_c4_ack0_low", 32'(ACK0), 0);

        // Read on port 1 with three data-phase wait states
        REQ1 = 1'b1; WR1 = 1'b0; ADDR1 = 32'h2000;
        tick;
        check("rd_c1_htrans", 32'(HTRANS), 32'h2);
        check("rd_c1_haddr", HADDR, 32'h2000);
        for (int c = 2; c <= 5; c++) begin
            tick;
            if (c == 2) HREADY = 1'b0;
            if (c == 5) begin HREADY = 1'b1; HRDATA = 32'h12345678; end
            check("rd_haddr_hold", HADDR, 32'h2000);
            check("rd_no_early_ack", 32'(ACK1), 0);
        end
        tick;
        check("rd_c6_ack1", 32'(ACK1), 1);
        check("rd_c6_rdata1", RDATA1, 32'h12345678);
        REQ1 = 1'b0;
        tick;

        // Contention: both ports hold reads for four transfers
        REQ0 = 1'b1; REQ1 = 1'b1; WR0 = 1'b0; WR1 = 1'b0;
        ADDR0 = 32'hA00; ADDR1 = 32'hB00; HRDATA = 32'h0000C0DE;
        n_rr = 0; n_fp = 0;
        for (int c = 0; c < 40 && n_rr < 4; c++) begin
            tick;
            if ((ACK0 || ACK1) && n_rr < 4) begin ord_rr[n_rr] = ACK1 ? 1 : 0; n_rr++; end
            if ((f_ACK0 || f_ACK1) && n_fp < 4) begin ord_fp[n_fp] = f_ACK1 ? 1 : 0; n_fp++; end
            if (n_rr == 4) begin REQ0 = 1'b0; REQ1 = 1'b0; end
        end
        check("rr_grant_count", n_rr, 4);
        check("fp_grant_count", n_fp, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < n_rr) check("rr_grant_order", ord_rr[i], exp_rr[i]);
            if (i < n_fp) check("fp_grant_order", ord_fp[i], 0);
        end
        check("rr_rdata0", RDATA0, 32'h0000C0DE);
        tick;

        // Two-cycle error response on port 0
        REQ0 = 1'b1; WR0 = 1'b0; ADDR0 = 32'h3000; HRDATA = 32'hBAD0BAD0;
        tick;
        check("er_c1_htrans", 32'(HTRANS), 32'h2);
        tick;
        HREADY = 1'b0; HRESP = 1'b1;
        tick;
        HREADY = 1'b1; HRESP = 1'b1;
        check("er_c3_no_ack", 32'(ACK0), 0);
        tick;
        check("er_c4_ack0", 32'(ACK0), 1);
        check("er_c4_err0", 32'(ERR0), 1);
        check("er_rdata0_kept", RDATA0, 32'h0000C0DE);
        REQ0 = 1'b0; HRESP = 1'b0;
        tick;

        // Watchdog abort with HREADY stuck low in the data phase
        REQ0 = 1'b1; WR0 = 1'b1; ADDR0 = 32'h5000; WDATA0 = 32'h77;
        tick;
        tick;
        HREADY = 1'b0;
        ack_cyc = -1;
        for (int c = 3; c <= 25 && ack_cyc < 0; c++) begin
            tick;
            if (ACK0) ack_cyc = c;
        end
        check("to_ack_cycle", ack_cyc, 10);
        check("to_err0", 32'(ERR0), 1);
        check("to_flag", 32'(TIMEOUT_FLAG), 1);
        REQ0 = 1'b0; HREADY = 1'b1;
        tick;
        check("to_flag_sticky", 32'(TIMEOUT_FLAG), 1);

        // Reset during the data phase, then a clean transfer
        REQ0 = 1'b1; WR0 = 1'b1; ADDR0 = 32'h4000; WDATA0 = 32'h55AA;
        tick;
        tick;
        HREADY = 1'b0; RST = 1'b1;
        tick;
        check("mr_htrans", 32'(HTRANS), 0);
        check("mr_haddr", HADDR, 0);
        check("mr_hwdata", HWDATA, 0);
        check("mr_no_ack", 32'(ACK0), 0);
        check("mr_tflag_clr", 32'(TIMEOUT_FLAG), 0);
        RST = 1'b0; HREADY = 1'b1;
        tick;
        check("mr_c1_htrans", 32'(HTRANS), 32'h2);
        check("mr_c1_haddr", HADDR, 32'h4000);
        tick;
        check("mr_c2_hwdata", HWDATA, 32'h55AA);
        tick;
        check("mr_c3_ack0", 32'(ACK0), 1);
        check("mr_c3_err0", 32'(ERR0), 0);
        REQ0 = 1'b0;
        tick;

        // Randomized traffic against the model
        RST = 1'b1;
        tick;
        RST = 1'b0;
        stuck = 0;
        for (int c = 0; c < 3000; c++) begin
            tick;
            if (stuck > 0) stuck--;
            else if ($urandom_range(0, 199) == 0) stuck = 12;
            HREADY = (stuck > 0) ? 1'b0 : ($urandom_range(0, 9) < 7);
            HRESP  = ($urandom_range(0, 9) < 2);
            HRDATA = $urandom;
            if (!REQ0 || e_ack[0]) REQ0 = ($urandom_range(0, 2) != 0);
            if (!REQ1 || e_ack[1]) REQ1 = ($urandom_range(0, 2) != 0);
            WR0 = $urandom_range(0, 1); WR1 = $urandom_range(0, 1);
            ADDR0 = $urandom; ADDR1 = $urandom;
            WDATA0 = $urandom; WDATA1 = $urandom;
            RST = ($urandom_range(0, 499) == 0);
        end
        RST = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
        tick; tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
